// File: rtl/cnn_pkg.sv
// Shared layer codes and sequencer state encoding for the CNN layer sequencer.
package cnn_pkg;

    localparam logic [7:0] LAYER_IDLE  = 8'd0;
    localparam logic [7:0] LAYER_LOAD  = 8'd1;
    localparam logic [7:0] LAYER_CONV1 = 8'd2;
    localparam logic [7:0] LAYER_POOL1 = 8'd3;
    localparam logic [7:0] LAYER_CONV2 = 8'd4;
    localparam logic [7:0] LAYER_POOL2 = 8'd5;
    localparam logic [7:0] LAYER_FC    = 8'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_DONE,
        S_ERROR
    } seq_state_t;

    function automatic logic [7:0] layer_code(input logic [2:0] layer);
        return {5'd0, layer};
    endfunction

endpackage

// File: rtl/cnn_layer_seq_if.sv
// Host and layer-controller signals of the CNN layer sequencer, plus its state.
interface cnn_layer_seq_if;
    import cnn_pkg::*;

    // Handshake: start and img_loaded are single-clock pulses sampled on the
    // rising edge; return_ctrl is a level, and a layer completes on any edge
    // where it equals the code currently driven on ctrl (nonzero).
    logic        start;
    logic        abort;
    logic        img_loaded;
    logic [7:0]  return_ctrl;
    logic [7:0]  ctrl;
    logic        busy;
    logic        done;
    logic        err;
    logic        irq;
    logic [2:0]  cur_layer;
    logic [2:0]  err_layer;
    logic [31:0] total_cycles;
    seq_state_t  dbg_state;

    modport master (
        output start, abort, img_loaded, return_ctrl,
        input  ctrl, busy, done, err, irq, cur_layer, err_layer, total_cycles, dbg_state
    );

    modport slave (
        input  start, abort, img_loaded, return_ctrl,
        output ctrl, busy, done, err, irq, cur_layer, err_layer, total_cycles, dbg_state
    );

endinterface

// File: rtl/cnn_layer_timer.sv
// Per-layer watchdog: counts enabled clocks from a clear and flags the last one.
module cnn_layer_timer #(
    parameter int LIMIT = 1048576
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + W'(1);
        end
    end

    // Asserted during the LIMIT-th enabled clock; the owner decides on the next edge.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/cnn_layer_seq.sv
// CNN layer sequencer: drives image load, then conv1..FC one layer at a time,
// with settle gaps between layers and a watchdog on every load/run phase.
module cnn_layer_seq
    import cnn_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int SETTLE_CYCLES  = 2
) (
    input logic            clk,
    input logic            reset,
    cnn_layer_seq_if.slave bus
);

    seq_state_t state;
    logic [3:0] settle_cnt;
    logic       wd_active;
    logic       wd_expired;
    logic       step_done;
    logic [2:0] next_layer;

    assign wd_active  = (state == S_LOAD) || (state == S_RUN);
    assign next_layer = bus.cur_layer + 3'd1;
    assign step_done  = (state == S_LOAD) ? bus.img_loaded
                                          : (bus.return_ctrl == layer_code(bus.cur_layer));
    assign bus.dbg_state = state;

    // Held in clear outside LOAD/RUN, so every entry to those states starts at zero.
    cnn_layer_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (!wd_active),
        .enable (wd_active),
        .expired(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            settle_cnt       <= 4'd0;
            bus.ctrl         <= LAYER_IDLE;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.err          <= 1'b0;
            bus.irq          <= 1'b0;
            bus.cur_layer    <= 3'd0;
            bus.err_layer    <= 3'd0;
            bus.total_cycles <= 32'd0;
        end else begin
            bus.irq <= 1'b0;
            if ((wd_active || (state == S_SETTLE)) && (bus.total_cycles != '1)) begin
                bus.total_cycles <= bus.total_cycles + 32'd1;
            end

            if (bus.abort) begin
                state         <= S_IDLE;
                bus.ctrl      <= LAYER_IDLE;
                bus.busy      <= 1'b0;
                bus.cur_layer <= 3'd0;
            end else begin
                case (state)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (bus.start) begin
                            state            <= S_LOAD;
                            bus.ctrl         <= LAYER_LOAD;
                            bus.busy         <= 1'b1;
                            bus.cur_layer    <= 3'd1;
                            bus.done         <= 1'b0;
                            bus.err          <= 1'b0;
                            bus.err_layer    <= 3'd0;
                            bus.total_cycles <= 32'd0;
                        end
                    end
                    // Completion is tested before the watchdog so it wins a same-cycle tie.
                    S_LOAD, S_RUN: begin
                        if (step_done) begin
                            bus.ctrl <= LAYER_IDLE;
                            if ((state == S_RUN) && (bus.cur_layer == LAYER_FC[2:0])) begin
                                state         <= S_DONE;
                                bus.busy      <= 1'b0;
                                bus.done      <= 1'b1;
                                bus.irq       <= 1'b1;
                                bus.cur_layer <= 3'd0;
                            end else begin
                                state      <= S_SETTLE;
                                settle_cnt <= 4'd0;
                            end
                        end else if (wd_expired) begin
                            state         <= S_ERROR;
                            bus.ctrl      <= LAYER_IDLE;
                            bus.busy      <= 1'b0;
                            bus.err       <= 1'b1;
                            bus.irq       <= 1'b1;
                            bus.err_layer <= bus.cur_layer;
                            bus.cur_layer <= 3'd0;
                        end
                    end
                    S_SETTLE: begin
                        if (settle_cnt == 4'(SETTLE_CYCLES - 1)) begin
                            state         <= S_RUN;
                            bus.cur_layer <= next_layer;
                            bus.ctrl      <= layer_code(next_layer);
                        end else begin
                            settle_cnt <= settle_cnt + 4'd1;
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        bus.ctrl <= LAYER_IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/cnn_layer_seq.md
CNN_LAYER_SEQ -- requirements
Module: cnn_layer_seq

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1048576, the per-layer watchdog limit in clocks.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 2, the number of ctrl=0 clocks between layers (range 1..15).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  reset reset, synchronous, active-high.
REQ-005 start  in  1  one-cycle pulse that launches one inference.
REQ-006 abort  in  1  level; returns the block to IDLE.
REQ-007 img_loaded  in  1  pulse from the host image writer; the image buffer is full.
REQ-008 return_ctrl  in  8  layer-completion code from the layer controller.
REQ-009 ctrl  out  8  layer-select code to the layer controller (registered).
REQ-010 busy  out  1  high in LOAD, SETTLE and RUN.
REQ-011 done  out  1  sticky success flag.
REQ-012 err  out  1  sticky timeout flag.
REQ-013 irq  out  1  one-cycle pulse on entry to DONE or ERROR.
REQ-014 cur_layer  out  3  layer currently being sequenced (0 = idle).
REQ-015 err_layer  out  3  layer index at which the timeout occurred.
REQ-016 total_cycles  out  32  clocks counted from LOAD entry to DONE entry; saturates at all-ones.

Function
REQ-017 Layer codes SHALL be: 1 = image load, 2 = conv1, 3 = pool1, 4 = conv2, 5 = pool2, 6 = FC; 0 = idle/reset-all.
REQ-018 The FSM SHALL have the states IDLE, LOAD, SETTLE, RUN, DONE and ERROR.
REQ-019 IDLE: ctrl=0; a start pulse SHALL move to LOAD with cur_layer=1, clear done, err and total_cycles, and clear err_layer to 0.
REQ-020 LOAD: ctrl=1; img_loaded=1 SHALL move to SETTLE.
REQ-021 SETTLE: ctrl=0 for exactly SETTLE_CYCLES clocks; then cur_layer SHALL increment and the FSM SHALL enter RUN.
REQ-022 RUN: ctrl=cur_layer; return_ctrl==cur_layer sampled on a clock edge SHALL complete the layer.
REQ-023 On layer completion, the FSM SHALL enter DONE if cur_layer==6; otherwise it SHALL enter SETTLE.
REQ-024 The ctrl output SHALL change on the clock edge after the transition condition is sampled (one-cycle latency).
REQ-025 DONE: ctrl=0, done=1, cur_layer=0; a start pulse SHALL launch a new run.
REQ-026 ERROR: ctrl=0, err=1, err_layer=layer at timeout, cur_layer=0; only start (new run) or reset SHALL leave ERROR.
REQ-027 The watchdog SHALL clear on every entry to LOAD or RUN and count each clock spent in that state.
REQ-028 When the watchdog reaches TIMEOUT_CYCLES-1 without completion, the FSM SHALL enter ERROR on the next edge.
REQ-029 If completion and timeout occur in the same cycle, completion SHALL win.
REQ-030 A start pulse while busy=1 SHALL be ignored.
REQ-031 abort=1 in any state SHALL force IDLE on the next edge with ctrl=0 and cur_layer=0, with no irq, leaving done and err unchanged.
REQ-032 If start and abort are asserted together, abort SHALL win.
REQ-033 The irq output SHALL be exactly one clock wide, asserted in the first cycle of DONE or ERROR.
REQ-034 return_ctrl values not equal to cur_layer SHALL be ignored (no partial or previous-layer acceptance).

Reset
REQ-035 On reset: state=IDLE, ctrl=0, busy=0, done=0, err=0, irq=0, cur_layer=0, err_layer=0, total_cycles=0, and both the watchdog and settle counters cleared.
REQ-036 Reset SHALL override abort, start and every other input in the same cycle.

Structure
REQ-037 Package cnn_pkg SHALL hold the layer-code constants (LAYER_IDLE..LAYER_FC) and the FSM state enum typedef.
REQ-038 The watchdog SHALL be one sub-module, cnn_layer_timer, with inputs clear and enable, parameter LIMIT, and output expired.
REQ-039 All outputs SHALL be registered; there SHALL be no combinational path from input to output.

Verification
REQ-040 Nominal run: start; img_loaded at cycle 5; return_ctrl echoes each code 10 clocks after it appears -> ctrl sequence 1,0,0,2,0,0,3,0,0,4,0,0,5,0,0,6,0, then done=1 and a single irq.
REQ-041 Timeout: TIMEOUT_CYCLES=64, return_ctrl held at 2 during conv2 -> err=1, err_layer=4, irq once, ctrl=0.
REQ-042 Abort: abort during RUN at layer 3 -> IDLE next edge, ctrl=0, no irq, done=0.
REQ-043 Collision: completion on the exact timeout cycle -> layer completes and no error; start during busy -> ignored; start+abort together in IDLE -> stays IDLE.
REQ-044 Reset mid-run: reset in SETTLE after layer 4 -> all outputs at their reset values next edge; a subsequent start runs cleanly.
REQ-045 Stale code: return_ctrl=2 held while in RUN of layer 3 -> no advance until return_ctrl=3.
